// File: rtl/graph_pkg.sv
// -----------------------------------------------------------------------------
// graph_pkg
//   Shared constants and types for the graph elementwise EXP engine.
//   FRAC      : round(2^(j/16) * 128) for j = 0..15. This is the mantissa table
//               used in place of a full 256-entry exp ROM.
//   LOG2E_Q12 : log2(e)/32 in Q12 format (185/4096), applied to the int8 input.
//   N_STAGE   : datapath depth, fixed by the stage split; it sets the latency.
//   exp_state_e : job-control FSM states.
// -----------------------------------------------------------------------------
package graph_pkg;

  localparam int N_STAGE = 3;

  localparam logic signed [16:0] LOG2E_Q12 = 17'sd185;

  localparam logic [7:0] FRAC [16] = '{
    8'd128, 8'd134, 8'd140, 8'd146, 8'd152, 8'd159, 8'd166, 8'd173,
    8'd181, 8'd189, 8'd197, 8'd206, 8'd215, 8'd225, 8'd235, 8'd245
  };

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } exp_state_e;

endpackage

// File: rtl/graph_exp_core.sv
// -----------------------------------------------------------------------------
// graph_exp_core
//   Three-stage int8 exp datapath:  y = clamp(round(exp(x/32)*32), 0, 127).
//   S1: p = x*185, n = p>>>12 (floor), j = p[11:8]
//   S2: F = FRAC[j], s = 2-n, saturate flag when n >= 2
//   S3: r = (F + 2^(s-1)) >> s, clamped to 127
//   Every stage moves together when advance is high. When advance is low,
//   every stage holds, so the output word stays stable.
// Ports
//   clk, rst      clock, synchronous active-high reset
//   advance       shift enable for the whole pipe
//   in_valid      element entering S1 (already handshaked)
//   in_last       element is the final one of the job
//   in_data       signed int8 x
//   out_valid     S3 holds a result
//   out_last      result is the final one of the job
//   out_data      result, 0..127
//   out_sat       result was clamped (only with GRAPH_EXP_STATS_EN)
// -----------------------------------------------------------------------------
module graph_exp_core
  import graph_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic       in_valid,
  input  logic       in_last,
  input  logic [7:0] in_data,
`ifdef GRAPH_EXP_STATS_EN
  output logic       out_sat,
`endif
  output logic       out_valid,
  output logic       out_last,
  output logic [7:0] out_data
);

  logic [N_STAGE-1:0] vld_pipe;
  logic [N_STAGE-1:0] last_pipe;

  logic signed [16:0] x_ext;
  logic signed [4:0]  s1_n;
  logic [3:0]         s1_j;
  logic [7:0]         s2_f;
  logic [3:0]         s2_sh;
  logic               s2_sat;

  logic [8:0] s3_rnd;
  logic [8:0] s3_sum;
  logic [8:0] s3_r;
  logic       s3_sat;
  logic [7:0] s3_data;

  assign x_ext = {{9{in_data[7]}}, in_data};

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    s3_rnd  = 9'd1 << (s2_sh - 4'd1);
    s3_sum  = {1'b0, s2_f} + s3_rnd;
    s3_r    = s3_sum >> s2_sh;
    s3_sat  = s2_sat || (s3_r > 9'd127);
    s3_data = s3_sat ? 8'd127 : s3_r[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments, so each stage reads the
  // value its predecessor held before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers are reset along with the valids, so out_data
      // reads 0 after reset and not a stale value.
      vld_pipe  <= '0;
      last_pipe <= '0;
      s1_n      <= '0;
      s1_j      <= '0;
      s2_f      <= '0;
      s2_sh     <= '0;
      s2_sat    <= 1'b0;
      out_data  <= '0;
`ifdef GRAPH_EXP_STATS_EN
      out_sat   <= 1'b0;
`endif
    end else if (advance) begin
      vld_pipe  <= {vld_pipe[N_STAGE-2:0], in_valid};
      last_pipe <= {last_pipe[N_STAGE-2:0], in_last};
      // The product fits 17 signed bits. The arithmetic shift gives floor().
      s1_n      <= 5'((x_ext * LOG2E_Q12) >>> 12);
      s1_j      <= 4'((x_ext * LOG2E_Q12) >>> 8);
      s2_f      <= FRAC[s1_j];
      s2_sh     <= 4'(5'sd2 - s1_n);   // 1..8 whenever n <= 1
      s2_sat    <= (s1_n > 5'sd1);
      out_data  <= s3_data;
`ifdef GRAPH_EXP_STATS_EN
      out_sat   <= s3_sat;
`endif
    end
  end

  assign out_valid = vld_pipe[N_STAGE-1];
  assign out_last  = last_pipe[N_STAGE-1];

endmodule

// File: rtl/graph_exp_stream.sv
// -----------------------------------------------------------------------------
// graph_exp_stream
//   Streaming int8 EXP engine. It is the inverse of the graph LOG table and uses
//   the same scale (int8 = float*32). A job is LEN elements. The results come
//   out in order, and done pulses one cycle after the last result is accepted.
//   Optional feature macro: GRAPH_EXP_STATS_EN adds the sat_cnt output.
// Ports
//   clk, rst               clock, synchronous active-high reset
//   start, len             launch a job of len elements (sampled in IDLE)
//   busy                   accepted start .. done pulse (inclusive)
//   done                   1-cycle job-complete pulse
//   in_valid/in_ready/in_data      input stream (signed int8)
//   out_valid/out_ready/out_data   output stream (0..127)
//   out_last               final element of the job, qualified by out_valid
//   sat_cnt                clamped outputs in current job (GRAPH_EXP_STATS_EN)
// -----------------------------------------------------------------------------
module graph_exp_stream
  import graph_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
`ifdef GRAPH_EXP_STATS_EN
  output logic [LEN_W-1:0] sat_cnt,
`endif
  output logic             out_last
);

  exp_state_e       state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] in_cnt;
  logic [LEN_W-1:0] out_cnt;

  logic advance;
  logic in_fire;
  logic out_fire;
  logic start_ok;
  logic in_is_last;

  // Stall-all pipe: any stage can move only when the output slot is free.
  assign advance    = !out_valid || out_ready;
  assign in_ready   = (state == RUN) && (in_cnt < len_q) && advance;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  // busy is still high during the done cycle, so a start there is ignored.
  assign start_ok   = start && (state == IDLE) && !busy;
  assign in_is_last = (in_cnt == len_q - LEN_W'(1));

`ifdef GRAPH_EXP_STATS_EN
  logic core_sat;
`endif

  graph_exp_core u_core (
    .clk       (clk),
    .rst       (rst),
    .advance   (advance),
    .in_valid  (in_fire),
    .in_last   (in_fire && in_is_last),
    .in_data   (in_data),
`ifdef GRAPH_EXP_STATS_EN
    .out_sat   (core_sat),
`endif
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      len_q   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start_ok) begin
            len_q   <= len;
            in_cnt  <= '0;
            out_cnt <= '0;
            busy    <= 1'b1;
            if (len == '0) done  <= 1'b1;   // empty job: complete at once
            else           state <= RUN;
          end
        end
        RUN: begin
          if (in_fire) in_cnt <= in_cnt + LEN_W'(1);
          if (out_fire) begin
            out_cnt <= out_cnt + LEN_W'(1);
            if (out_cnt == len_q - LEN_W'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GRAPH_EXP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok)         sat_cnt <= '0;
    else if (out_fire && core_sat) sat_cnt <= sat_cnt + LEN_W'(1);
  end
`endif

endmodule
